// File: rtl/mixcolumns_seq_if.sv
// Handshake and state bus between the ShiftRows output, the MixColumns stage and the round controller.
// The master drives the start level and the shifted state; the slave returns the mixed state and status.
interface mixcolumns_seq_if;
    logic         colenable;
    logic [127:0] shiftedmatrix;
    logic [127:0] mixedmatrix;
    logic         colsdone;
    logic         colsbusy;

    modport master (
        output colenable,
        output shiftedmatrix,
        input  mixedmatrix,
        input  colsdone,
        input  colsbusy
    );

    modport slave (
        input  colenable,
        input  shiftedmatrix,
        output mixedmatrix,
        output colsdone,
        output colsbusy
    );
endinterface

// File: rtl/mixcolumns_seq.sv
// AES MixColumns, COLS_PER_CYCLE columns per clock; result and colsdone arrive 1+4/C edges after start.
// No backpressure: a start is accepted only from IDLE, and starts seen while busy are dropped, not queued.
module mixcolumns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic             int_osc,
    input  logic             reset,
    mixcolumns_seq_if.slave  bus
);

    localparam int NCOL = 4;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_en_q;
    logic [1:0]   r_idx;
    logic [127:0] r_work;
    logic [127:0] r_result;
    logic [127:0] r_mixed;
    logic         r_done;
    logic         r_busy;
    logic         w_start;
    logic         w_last;
    logic         w_load;
    logic         w_fin;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes a0..a3 are ordered top-down, a0 in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Edge detect on the start level; a held level fires only once.
    assign w_start = bus.colenable & ~r_en_q;
    assign w_last  = (int'(r_idx) + COLS_PER_CYCLE) >= NCOL;

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_RUN;
                    w_load = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
                w_fin  = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            r_en_q   <= 1'b0;
            r_idx    <= 2'd0;
            r_work   <= '0;
            r_result <= '0;
            r_mixed  <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_en_q <= bus.colenable;
            r_done <= 1'b0;
            r_busy <= (w_next != S_IDLE);
            if (w_load) begin
                r_work <= bus.shiftedmatrix;
                r_idx  <= 2'd0;
            end
            if (r_state == S_RUN) begin
                for (int c = 0; c < NCOL; c++) begin
                    if (c >= int'(r_idx) && c < int'(r_idx) + COLS_PER_CYCLE) begin
                        r_result[127 - 32*c -: 32] <= mix_col(r_work[127 - 32*c -: 32]);
                    end
                end
                r_idx <= w_last ? 2'd0 : r_idx + 2'(COLS_PER_CYCLE);
            end
            if (w_fin) begin
                r_mixed <= r_result;
                r_done  <= 1'b1;
            end
        end
    end

    assign bus.mixedmatrix = r_mixed;
    assign bus.colsdone    = r_done;
    assign bus.colsbusy    = r_busy;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Runs the same start/state stimulus into three instances (1, 2 and 4 columns per cycle) and
// scoreboards each against an independent GF(2^8) matrix-multiply model.
module tb_mixcolumns_seq;

    logic int_osc = 1'b0;
    logic reset;
    logic en;
    logic [127:0] sm;
    int   cyc = 0;

    always #5 int_osc = ~int_osc;
    always @(posedge int_osc) cyc <= cyc + 1;

    mixcolumns_seq_if if1 ();
    mixcolumns_seq_if if2 ();
    mixcolumns_seq_if if4 ();

    assign if1.colenable = en;
    assign if2.colenable = en;
    assign if4.colenable = en;
    assign if1.shiftedmatrix = sm;
    assign if2.shiftedmatrix = sm;
    assign if4.shiftedmatrix = sm;

    mixcolumns_seq #(.COLS_PER_CYCLE(1)) u_c1 (.int_osc(int_osc), .reset(reset), .bus(if1.slave));
    mixcolumns_seq #(.COLS_PER_CYCLE(2)) u_c2 (.int_osc(int_osc), .reset(reset), .bus(if2.slave));
    mixcolumns_seq #(.COLS_PER_CYCLE(4)) u_c4 (.int_osc(int_osc), .reset(reset), .bus(if4.slave));

    logic [127:0] mm_a [3];
    logic         done_a [3];
    logic         busy_a [3];
    assign mm_a[0] = if1.mixedmatrix;
    assign mm_a[1] = if2.mixedmatrix;
    assign mm_a[2] = if4.mixedmatrix;
    assign done_a[0] = if1.colsdone;
    assign done_a[1] = if2.colsdone;
    assign done_a[2] = if4.colsdone;
    assign busy_a[0] = if1.colsbusy;
    assign busy_a[1] = if2.colsbusy;
    assign busy_a[2] = if4.colsbusy;

    typedef struct {
        logic [127:0] dat;
        int           start;
    } exp_t;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    exp_t q [3][$];
    int   done_edge [3] = '{-100, -100, -100};
    int   lat [3] = '{5, 3, 2};
    int   cpc [3] = '{1, 2, 4};
    logic [127:0] prev_mm [3] = '{128'd0, 128'd0, 128'd0};
    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] coef [4][4] = '{'{8'd2, 8'd3, 8'd1, 8'd1},
                                '{8'd1, 8'd2, 8'd3, 8'd1},
                                '{8'd1, 8'd1, 8'd2, 8'd3},
                                '{8'd3, 8'd1, 8'd1, 8'd2}};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'd0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   b;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b = 8'd0;
                for (int k = 0; k < 4; k++) begin
                    b = b ^ gmul(coef[r][k], s[127 - 32*c - 8*k -: 8]);
                end
                o[127 - 32*c - 8*r -: 8] = b;
            end
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge int_osc);
        #1;
    endtask

    // A 0->1 change is sampled at the next edge; each instance accepts it only once idle again.
    task automatic drive(input logic v, input logic [127:0] d, input logic [127:0] expd);
        int   se;
        exp_t e;
        se = cyc + 1;
        if (v && !en) begin
            for (int k = 0; k < 3; k++) begin
                if (se > done_edge[k]) begin
                    e.dat = expd;
                    e.start = se;
                    q[k].push_back(e);
                    done_edge[k] = se + lat[k];
                end
            end
        end
        en = v;
        sm = d;
        step();
    endtask

    task automatic op(input logic [127:0] d, input logic [127:0] expd);
        drive(1'b1, d, expd);
        drive(1'b0, d, expd);
        repeat (4) step();
    endtask

    task automatic check_quiet(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_mixed_c%0d", tag, cpc[k]), mm_a[k], 128'd0);
            chk($sformatf("%s_done_c%0d", tag, cpc[k]), 128'(done_a[k]), 128'd0);
            chk($sformatf("%s_busy_c%0d", tag, cpc[k]), 128'(busy_a[k]), 128'd0);
        end
    endtask

    always @(negedge int_osc) begin
        for (int k = 0; k < 3; k++) begin
            if (reset !== 1'b0) begin
                prev_mm[k] = mm_a[k];
            end else begin
                if (mm_a[k] !== prev_mm[k])
                    chk($sformatf("mixed_change_needs_done_c%0d", cpc[k]), 128'(done_a[k]), 128'd1);
                prev_mm[k] = mm_a[k];
                if (done_a[k] === 1'b1) begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("unexpected_colsdone_c%0d", cpc[k]), 128'(done_a[k]), 128'd0);
                    end else begin
                        exp_t e;
                        e = q[k].pop_front();
                        chk($sformatf("result_c%0d", cpc[k]), mm_a[k], e.dat);
                        chk($sformatf("latency_c%0d", cpc[k]), 128'(cyc - e.start), 128'(lat[k]));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        logic [127:0] d;
        int   waited;

        tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        tbl[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
        tbl[2] = '{128'h0, 128'h0};
        tbl[3] = '{{128{1'b1}}, {128{1'b1}}};

        reset = 1'b1;
        en = 1'b0;
        sm = '0;
        step();
        check_quiet("reset");
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) op(tbl[i].din, tbl[i].dexp);

        // Level held high: one operation only; a fresh rising edge starts another.
        d = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        drive(1'b1, d, mix_ref(d));
        repeat (20) drive(1'b1, d, mix_ref(d));
        drive(1'b0, d, mix_ref(d));
        d = 128'h1122_3344_5566_7788_99aa_bbcc_ddee_ff00;
        op(d, mix_ref(d));

        // Restart while busy is dropped, and input changes after start are ignored.
        d = tbl[1].din;
        drive(1'b1, d, tbl[1].dexp);
        drive(1'b0, d, tbl[1].dexp);
        drive(1'b1, tbl[0].din, tbl[0].dexp);
        drive(1'b1, 128'hdead_beef_0000_ffff_1234_5678_9abc_def0, 128'd0);
        drive(1'b0, 128'hdead_beef_0000_ffff_1234_5678_9abc_def0, 128'd0);
        repeat (6) step();

        // Reset during the second RUN cycle abandons the operation.
        drive(1'b1, tbl[0].din, tbl[0].dexp);
        drive(1'b0, tbl[0].din, tbl[0].dexp);
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            done_edge[k] = -100;
        end
        step();
        step();
        reset = 1'b0;
        repeat (8) step();
        op(tbl[1].din, tbl[1].dexp);

        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            op(d, mix_ref(d));
        end

        waited = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && waited < 50) begin
            step();
            waited++;
        end
        repeat (4) step();
        for (int k = 0; k < 3; k++)
            chk($sformatf("drain_c%0d", cpc[k]), 128'(q[k].size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
